// File: rtl/seq_run_scheduler.sv
// seq_run_scheduler
// Job controller around a run-of-equal-bits detector. A parallel word is
// captured on an accepted start request, streamed MSB-first one bit per cycle,
// and every bit position whose run of equal bits reaches RUN_LEN is counted as
// a hit. Hits overlap: each further equal bit in a long run is another hit.
//
// Ports
//   i_clk            posedge clock
//   i_rst            synchronous active-high reset (aborts a running job)
//   i_start          job request, sampled only in IDLE
//   i_data_in        job word, captured on the accepting edge
//   o_busy           high in SHIFT and DONE
//   o_done           one-cycle pulse in DONE
//   o_serial_out     bit being streamed (0 outside SHIFT)
//   o_hit_count      number of hit positions (saturating)
//   o_first_hit_idx  index (0 = MSB) of the first hit, 0 if none
//   o_any_hit        high when at least one hit was seen
//   o_curr_state     FSM state: 0 IDLE, 1 SHIFT, 2 DONE
module seq_run_scheduler #(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned RUN_LEN = 4,
   parameter int unsigned CNT_W   = 5,
   parameter int unsigned IDX_W   = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [WORD_W-1:0] i_data_in,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_serial_out,
   output logic [CNT_W-1:0]  o_hit_count,
   output logic [IDX_W-1:0]  o_first_hit_idx,
   output logic              o_any_hit,
   output logic [1:0]        o_curr_state
);

   localparam int unsigned RL_W = $clog2(RUN_LEN + 1);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORD_W - 1);
   localparam logic [RL_W-1:0]  RunMax  = RL_W'(RUN_LEN);
   localparam logic [RL_W-1:0]  RunOne  = RL_W'(1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e            r_state;
   logic [WORD_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [RL_W-1:0]   r_run_len;
   logic              r_prev;
   logic [CNT_W-1:0]  r_hit_count;
   logic [IDX_W-1:0]  r_first_hit_idx;
   logic              r_any_hit;
   logic              r_busy;
   logic              r_done;

   logic              w_bit;
   logic [RL_W-1:0]   w_run_nxt;
   logic              w_hit;

   assign w_bit = r_shreg[WORD_W-1];

   // Run length saturates at RUN_LEN so every further equal bit still reads as a hit.
   always_comb begin
      w_run_nxt = RunOne;
      if (r_bit_idx != '0 && w_bit == r_prev) begin
         w_run_nxt = (r_run_len >= RunMax) ? RunMax : r_run_len + 1'b1;
      end
   end

   assign w_hit = (w_run_nxt == RunMax);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= StIdle;
         r_shreg         <= '0;
         r_bit_idx       <= '0;
         r_run_len       <= '0;
         r_prev          <= 1'b0;
         r_hit_count     <= '0;
         r_first_hit_idx <= '0;
         r_any_hit       <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_shreg         <= i_data_in;
                  r_bit_idx       <= '0;
                  r_run_len       <= '0;
                  r_hit_count     <= '0;
                  r_first_hit_idx <= '0;
                  r_any_hit       <= 1'b0;
                  r_busy          <= 1'b1;
                  r_state         <= StShift;
               end
            end
            StShift: begin
               r_shreg   <= r_shreg << 1;
               r_bit_idx <= r_bit_idx + 1'b1;
               r_prev    <= w_bit;
               r_run_len <= w_run_nxt;
               if (w_hit) begin
                  if (r_hit_count != '1) begin
                     r_hit_count <= r_hit_count + 1'b1;
                  end
                  if (!r_any_hit) begin
                     r_first_hit_idx <= r_bit_idx;
                     r_any_hit       <= 1'b1;
                  end
               end
               if (r_bit_idx == LastIdx) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_serial_out    = (r_state == StShift) ? w_bit : 1'b0;
   assign o_hit_count     = r_hit_count;
   assign o_first_hit_idx = r_first_hit_idx;
   assign o_any_hit       = r_any_hit;
   assign o_curr_state    = r_state;

endmodule

// File: tb/tb_seq_run_scheduler.sv
// Bench for seq_run_scheduler: directed vector table, random words against a
// window-based reference model, mid-job reset and back-to-back jobs.
module tb_seq_run_scheduler;

   localparam int WORD_W  = 16;
   localparam int RUN_LEN = 4;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [15:0] i_data_in;
   logic        o_busy;
   logic        o_done;
   logic        o_serial_out;
   logic [4:0]  o_hit_count;
   logic [3:0]  o_first_hit_idx;
   logic        o_any_hit;
   logic [1:0]  o_curr_state;

   int n_tests = 0;
   int n_fail  = 0;

   seq_run_scheduler #(
      .WORD_W (16),
      .RUN_LEN(4),
      .CNT_W  (5),
      .IDX_W  (4)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_data_in      (i_data_in),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_serial_out   (o_serial_out),
      .o_hit_count    (o_hit_count),
      .o_first_hit_idx(o_first_hit_idx),
      .o_any_hit      (o_any_hit),
      .o_curr_state   (o_curr_state)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] data;
      int          cnt;
      int          idx;
      int          any;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // A hit at bit k (0 = MSB) means the RUN_LEN bits ending at k are all equal.
   function automatic void model(input logic [15:0] d, output int cnt, output int idx,
                                 output int any);
      cnt = 0;
      idx = 0;
      any = 0;
      for (int k = RUN_LEN - 1; k < WORD_W; k++) begin
         bit same = 1'b1;
         for (int j = k - RUN_LEN + 1; j <= k; j++) begin
            if (d[WORD_W-1-j] != d[WORD_W-1-k]) same = 1'b0;
         end
         if (same) begin
            if (cnt < 31) cnt++;
            if (any == 0) begin
               idx = k;
               any = 1;
            end
         end
      end
   endfunction

   // Launches one job, pulses start during SHIFT (must be ignored) and returns
   // in the DONE cycle (at its negedge) or after the cycle budget expires.
   task automatic run_job(input logic [15:0] d, output int lat, output logic [15:0] ser);
      @(negedge i_clk);
      i_start   = 1'b1;
      i_data_in = d;
      @(negedge i_clk);
      i_data_in = 16'($urandom);
      lat = 0;
      ser = '0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge i_clk);
         i_start = (c == 5 || c == 16);
         if (c <= 16) ser = {ser[14:0], o_serial_out};
         if (o_done) begin
            lat = c;
            break;
         end
      end
      i_start = 1'b0;
   endtask

   task automatic job_and_check(input string tag, input logic [15:0] d, input int cnt,
                                input int idx, input int any);
      int          lat;
      logic [15:0] ser;
      run_job(d, lat, ser);
      check({tag, " latency"}, lat, 17);
      check({tag, " serial"}, int'(ser), int'(d));
      check({tag, " hit_count"}, int'(o_hit_count), cnt);
      check({tag, " first_hit_idx"}, int'(o_first_hit_idx), idx);
      check({tag, " any_hit"}, int'(o_any_hit), any);
      check({tag, " busy in done"}, int'(o_busy), 1);
      check({tag, " state in done"}, int'(o_curr_state), 2);
      @(negedge i_clk);
      check({tag, " done dropped"}, int'(o_done), 0);
      check({tag, " idle after"}, int'(o_curr_state), 0);
      check({tag, " busy idle"}, int'(o_busy), 0);
      check({tag, " serial idle"}, int'(o_serial_out), 0);
      check({tag, " held count"}, int'(o_hit_count), cnt);
   endtask

   initial begin
      int cnt, idx, any, ndone, lat1, lat2, cnt1, idx1, cnt2, idx2, st18;
      logic [15:0] d;

      vecs[0] = '{16'h0000, 13, 3, 1};
      vecs[1] = '{16'hAAAA, 0, 0, 0};
      vecs[2] = '{16'hF0F0, 4, 3, 1};
      vecs[3] = '{16'h7FFF, 12, 4, 1};
      vecs[4] = '{16'hFFFF, 13, 3, 1};
      vecs[5] = '{16'h0F0F, 4, 3, 1};
      vecs[6] = '{16'h8001, 11, 4, 1};
      vecs[7] = '{16'h3C3C, 3, 5, 1};

      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_data_in = '0;
      repeat (3) @(negedge i_clk);
      check("reset state", int'(o_curr_state), 0);
      check("reset busy", int'(o_busy), 0);
      check("reset done", int'(o_done), 0);
      check("reset serial", int'(o_serial_out), 0);
      check("reset hit_count", int'(o_hit_count), 0);
      check("reset first_hit_idx", int'(o_first_hit_idx), 0);
      check("reset any_hit", int'(o_any_hit), 0);
      i_rst = 1'b0;

      foreach (vecs[i]) begin
         job_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].cnt, vecs[i].idx,
                       vecs[i].any);
      end

      for (int i = 0; i < 25; i++) begin
         d = 16'($urandom);
         if (i % 5 == 0) d = d | 16'hF000;
         model(d, cnt, idx, any);
         job_and_check($sformatf("rand%0d_%04h", i, d), d, cnt, idx, any);
      end

      // Reset on the 6th SHIFT cycle of an all-zero job.
      @(negedge i_clk);
      i_start   = 1'b1;
      i_data_in = 16'h0000;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (5) @(negedge i_clk);
      check("midjob count before reset", int'(o_hit_count), 2);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("midjob reset state", int'(o_curr_state), 0);
      check("midjob reset busy", int'(o_busy), 0);
      check("midjob reset count", int'(o_hit_count), 0);
      check("midjob reset idx", int'(o_first_hit_idx), 0);
      check("midjob reset any", int'(o_any_hit), 0);
      i_rst = 1'b0;
      ndone = 0;
      repeat (25) begin
         @(negedge i_clk);
         if (o_done) ndone++;
      end
      check("midjob no done pulse", ndone, 0);

      // start held high across two jobs.
      @(negedge i_clk);
      i_start   = 1'b1;
      i_data_in = 16'hFFFF;
      @(negedge i_clk);
      i_data_in = 16'h0F0F;
      ndone = 0;
      lat1 = 0; lat2 = 0; cnt1 = 0; idx1 = 0; cnt2 = 0; idx2 = 0; st18 = -1;
      for (int c = 1; c <= 45; c++) begin
         if (c > 1) @(negedge i_clk);
         if (o_done) begin
            ndone++;
            if (ndone == 1) begin
               lat1 = c; cnt1 = int'(o_hit_count); idx1 = int'(o_first_hit_idx);
            end else if (ndone == 2) begin
               lat2 = c; cnt2 = int'(o_hit_count); idx2 = int'(o_first_hit_idx);
            end
         end
         if (c == 18) st18 = int'(o_curr_state);
         if (c == 35) i_start = 1'b0;
      end
      check("b2b done pulses", ndone, 2);
      check("b2b first latency", lat1, 17);
      check("b2b idle gap state", st18, 0);
      check("b2b second latency", lat2, 35);
      check("b2b job1 count", cnt1, 13);
      check("b2b job1 idx", idx1, 3);
      check("b2b job2 count", cnt2, 4);
      check("b2b job2 idx", idx2, 3);
      check("b2b final idle", int'(o_curr_state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
